// File: rtl/rvfi_pkg.sv
// RVFI commit-record type, reduced to the memory-write fields the HTIF responder
// consumes.
package rvfi_pkg;

    localparam int unsigned XLEN = 64;

    typedef struct packed {
        logic              valid;
        logic [XLEN-1:0]   mem_addr;
        logic [XLEN/8-1:0] mem_wmask;
        logic [XLEN-1:0]   mem_wdata;
    } rvfi_instr_t;

endpackage

// File: rtl/rvfi_htif_responder.sv
// Host-side HTIF responder: snoops RVFI stores to tohost, decodes exit/putchar
// commands and acknowledges each one by clearing tohost and writing fromhost.
module rvfi_htif_responder #(
    parameter int unsigned NR_COMMIT_PORTS = 2,
    parameter int unsigned FIFO_DEPTH      = 4,
    parameter int unsigned XLEN            = 64
) (
    input  logic                                      clk_i,
    input  logic                                      rst_ni,
    input  rvfi_pkg::rvfi_instr_t [NR_COMMIT_PORTS-1:0] rvfi_i,
    input  logic [63:0]                               tohost_addr_i,
    input  logic [63:0]                               fromhost_addr_i,
    output logic                                      req_o,
    output logic [63:0]                               req_addr_o,
    output logic [63:0]                               req_wdata_o,
    input  logic                                      gnt_i,
    output logic                                      char_valid_o,
    output logic [7:0]                                char_o,
    output logic                                      exit_valid_o,
    output logic [62:0]                               exit_code_o,
    output logic                                      unsupported_o,
    output logic                                      overflow_o
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [2:0] {
        IDLE,
        DECODE,
        CLR_TO,
        WR_FROM,
        DONE
    } state_e;

    // ------------------------------------------------------------------
    // Detection and multi-push FIFO
    // ------------------------------------------------------------------
    logic [NR_COMMIT_PORTS-1:0] detect;
    logic [NR_COMMIT_PORTS-1:0] push_en;
    logic [PTR_W-1:0]           push_slot [NR_COMMIT_PORTS];
    logic [CNT_W-1:0]           n_push;
    logic [CNT_W-1:0]           free_slots;
    logic                       overflow_set;
    logic                       pop;

    logic [XLEN-1:0]  fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    always_comb begin
        for (int p = 0; p < int'(NR_COMMIT_PORTS); p++) begin
            detect[p] = rvfi_i[p].valid
                     && (rvfi_i[p].mem_addr == tohost_addr_i)
                     && (rvfi_i[p].mem_wmask != '0)
                     && (rvfi_i[p].mem_wdata != '0)
                     && (tohost_addr_i != '0);
        end
    end

    // A slot freed by this cycle's pop is available to this cycle's pushes;
    // ports claim slots in ascending order so later ports are the ones dropped.
    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        n_push       = '0;
        overflow_set = 1'b0;
        push_en      = '0;
        free_slots   = CNT_W'(FIFO_DEPTH) - count_q + CNT_W'(pop);
        for (int p = 0; p < int'(NR_COMMIT_PORTS); p++) begin
            push_slot[p] = '0;
        end
        for (int p = 0; p < int'(NR_COMMIT_PORTS); p++) begin
            if (detect[p]) begin
                if (n_push < free_slots) begin
                    push_en[p]   = 1'b1;
                    push_slot[p] = wr_ptr_q + PTR_W'(n_push);
                    n_push       = n_push + CNT_W'(1);
                end else begin
                    overflow_set = 1'b1;
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignments only.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_o <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(n_push);
            rd_ptr_q <= rd_ptr_q + PTR_W'(pop);
            count_q  <= count_q + n_push - CNT_W'(pop);
            if (overflow_set) begin
                overflow_o <= 1'b1;
            end
        end
    end

    // NOTE: FIFO storage is not reset; occupancy is tracked by count_q alone.
    always_ff @(posedge clk_i) begin
        for (int p = 0; p < int'(NR_COMMIT_PORTS); p++) begin
            if (push_en[p]) begin
                fifo_mem[push_slot[p]] <= rvfi_i[p].mem_wdata;
            end
        end
    end

    // ------------------------------------------------------------------
    // Command FSM with registered outputs
    // ------------------------------------------------------------------
    state_e          state_q, state_d;
    logic [XLEN-1:0] cmd_q, cmd_d;
    logic            req_d;
    logic [63:0]     req_addr_d, req_wdata_d;
    logic            char_valid_d, exit_valid_d, unsupported_d;
    logic [7:0]      char_d;
    logic [62:0]     exit_code_d;
    logic            is_exit, is_putchar;

    assign is_exit    = (cmd_q[63:56] == 8'd0) && cmd_q[0];
    assign is_putchar = (cmd_q[63:56] == 8'd1) && (cmd_q[55:48] == 8'd1);

    always_comb begin
        state_d       = state_q;
        cmd_d         = cmd_q;
        pop           = 1'b0;
        req_d         = req_o;
        req_addr_d    = req_addr_o;
        req_wdata_d   = req_wdata_o;
        char_valid_d  = 1'b0;
        char_d        = char_o;
        exit_valid_d  = 1'b0;
        exit_code_d   = exit_code_o;
        unsupported_d = unsupported_o;

        unique case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    cmd_d   = fifo_mem[rd_ptr_q];
                    state_d = DECODE;
                end
            end
            DECODE: begin
                if (is_exit) begin
                    exit_valid_d = 1'b1;
                    exit_code_d  = {16'd0, cmd_q[47:1]};
                    state_d      = DONE;
                end else begin
                    if (is_putchar) begin
                        char_valid_d = 1'b1;
                        char_d       = cmd_q[7:0];
                    end else begin
                        unsupported_d = 1'b1;
                    end
                    state_d = CLR_TO;
                end
            end
            CLR_TO: begin
                // First cycle issues the request; the grant chains straight
                // into the fromhost write so req_o never drops in between.
                if (!req_o) begin
                    req_d       = 1'b1;
                    req_addr_d  = tohost_addr_i;
                    req_wdata_d = '0;
                end else if (gnt_i) begin
                    req_addr_d  = fromhost_addr_i;
                    req_wdata_d = {cmd_q[63:48], 48'h1};
                    state_d     = WR_FROM;
                end
            end
            WR_FROM: begin
                if (gnt_i) begin
                    req_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            cmd_q         <= '0;
            req_o         <= 1'b0;
            req_addr_o    <= '0;
            req_wdata_o   <= '0;
            char_valid_o  <= 1'b0;
            char_o        <= '0;
            exit_valid_o  <= 1'b0;
            exit_code_o   <= '0;
            unsupported_o <= 1'b0;
        end else begin
            state_q       <= state_d;
            cmd_q         <= cmd_d;
            req_o         <= req_d;
            req_addr_o    <= req_addr_d;
            req_wdata_o   <= req_wdata_d;
            char_valid_o  <= char_valid_d;
            char_o        <= char_d;
            exit_valid_o  <= exit_valid_d;
            exit_code_o   <= exit_code_d;
            unsupported_o <= unsupported_d;
        end
    end

endmodule

// File: doc/rvfi_htif_responder.md
Name: rvfi_htif_responder

Overview:
- Host-side counterpart to the RVFI tohost monitor.
- Watches the RVFI commit ports for stores into tohost and decodes each one as an HTIF command:
  - an exit command produces an exit report;
  - a console putchar produces a character output;
  - every command is acknowledged by clearing tohost and writing fromhost through a simple memory-write request port.
- Sits in the testbench or an FPGA wrapper beside the core, fed by its RVFI bus and driving a debug or memory write port.

Parameters:
- NR_COMMIT_PORTS, 2, number of RVFI commit ports monitored.
- FIFO_DEPTH, 4, pending-command FIFO entries; power of two, at least 2.
- XLEN, 64, data width; only 64 is supported.

Ports:
- clk_i  input  1  clock.
- rst_ni  input  1  reset, asynchronous, active-low.
- rvfi_i  input  rvfi_pkg::rvfi_instr_t[NR_COMMIT_PORTS-1:0]  RVFI commit records.
- tohost_addr_i  input  64  tohost address; a value of 0 disables detection.
- fromhost_addr_i  input  64  fromhost address.
- req_o  output  1  memory write request valid.
- req_addr_o  output  64  write address.
- req_wdata_o  output  64  write data (full dword).
- gnt_i  input  1  write accepted in this cycle when req_o is high.
- char_valid_o  output  1  one-cycle pulse: console character available.
- char_o  output  8  console character.
- exit_valid_o  output  1  one-cycle pulse: exit command decoded.
- exit_code_o  output  63  exit code (payload >> 1), held after the pulse.
- unsupported_o  output  1  sticky: an unknown command was seen.
- overflow_o  output  1  sticky: a command was dropped because the FIFO was full.

Behaviour:
- Reset values: all outputs 0, FIFO empty, FSM in IDLE.
- Detection, per port p, in one cycle: rvfi_i[p].valid && mem_addr==tohost_addr_i && mem_wmask!=0 && mem_wdata!=0 && tohost_addr_i!=0.
  - A detection pushes mem_wdata into the FIFO.
  - Several ports detecting in the same cycle push in ascending port order; up to NR_COMMIT_PORTS pushes per cycle.
  - A push that finds the FIFO full is dropped and sets overflow_o. Earlier ports in the same cycle still succeed.
  - The FIFO may be popped and pushed in the same cycle; a push into a slot freed by that pop succeeds.
- Command decode uses cmd=w[63:56] (dev), w[55:48] (cmd), w[47:0] (payload).
  - EXIT: dev==0 and payload[0]==1.
  - PUTCHAR: dev==1, cmd==1.
  - Anything else: UNSUPPORTED.
- FSM states: IDLE, DECODE, CLR_TO, WR_FROM, DONE.
  - IDLE: FIFO non-empty -> pop the head into the command register, go to DECODE.
  - DECODE (one cycle):
    - EXIT: pulse exit_valid_o, latch exit_code_o=payload[47:1] zero-extended to 63 bits, go to DONE.
    - PUTCHAR: pulse char_valid_o with char_o=payload[7:0], go to CLR_TO.
    - UNSUPPORTED: set unsupported_o, go to CLR_TO.
  - CLR_TO: req_o=1, addr=tohost_addr_i, wdata=0. On gnt_i -> WR_FROM.
  - WR_FROM: req_o=1, addr=fromhost_addr_i, wdata={dev,cmd,48'h1}. On gnt_i -> IDLE.
  - DONE: terminal until reset. No further requests or pulses; FIFO pushes are still counted for overflow.
- Request handshake:
  - req_o, req_addr_o and req_wdata_o are registered and stay stable until the cycle in which gnt_i is sampled high.
  - gnt_i may arrive in the first cycle of req_o.
  - req_o drops in the cycle after the grant unless the next write starts.
  - gnt_i while req_o is low is ignored.
- Latency:
  - Detect at edge N -> FIFO valid.
  - Pop at N+1 -> DECODE at N+2.
  - char_valid_o / exit_valid_o are high during the cycle after N+2.
  - req_o rises one cycle later.
- Mid-operation and reset:
  - Reset while req_o is high abandons the request; req_o is 0 immediately (asynchronous).
  - Address inputs are sampled when each request is issued.
- Stores into fromhost, and stores of value 0 into tohost, are ignored.

Test Plan:
- Putchar: port 0 valid store of 0x0101_0000_0000_0041 to tohost 0x8000_1000; gnt_i tied high -> char 0x41 pulses once, then request 0x8000_1000 data 0, then request to fromhost with data 0x0101_0000_0000_0001, then IDLE.
- Exit: store of 0x0000_0000_0000_0007 -> exit_valid_o pulses once with exit_code_o=3. No req_o follows. A later putchar store produces nothing.
- Dual-port same cycle: port 0 putchar 'A', port 1 putchar 'B'; gnt_i delayed 3 cycles each -> chars A then B in order, four writes total, each request held stable until its grant.
- Overflow: FIFO_DEPTH=4, gnt_i held low, six putchar stores -> overflow_o set, and exactly 4 chars emitted after gnt_i is released.
- Filters: store to tohost with wdata=0, store with valid=0, wmask=0, and tohost_addr_i=0 -> no FIFO push, no outputs. Command dev=2 -> unsupported_o set, tohost cleared, fromhost written.
- Reset mid-request: assert rst_ni low while in WR_FROM -> req_o=0 asynchronously, all flags cleared; a new putchar after reset is handled normally.
